// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared state encoding and frame constants for imem_loader
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int unsigned c_state_w = 3;

  localparam logic [c_state_w-1:0] S_HDR0 = 3'd0;
  localparam logic [c_state_w-1:0] S_HDR1 = 3'd1;
  localparam logic [c_state_w-1:0] S_DATA = 3'd2;
  localparam logic [c_state_w-1:0] S_CSUM = 3'd3;
  localparam logic [c_state_w-1:0] S_DONE = 3'd4;
  localparam logic [c_state_w-1:0] S_ERR  = 3'd5;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream handshake and instruction-memory write port
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;

  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [31:0] wr_data_o;

  // Stream source and memory sink (bench / surrounding system)
  modport master (
    output byte_valid_i,
    output byte_data_i,
    input  byte_ready_o,
    input  wr_en_o,
    input  wr_addr_o,
    input  wr_data_o
  );

  // Loader view
  modport slave (
    input  byte_valid_i,
    input  byte_data_i,
    output byte_ready_o,
    output wr_en_o,
    output wr_addr_o,
    output wr_data_o
  );

endinterface : imem_loader_if
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : word_assembler
// Description : 8-to-32 big-endian shift register; pulses word_valid for one
//               cycle with the completed word, which then holds.
// Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
  import imem_loader_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        clear,
  input  wire logic        byte_en,
  input  wire logic [7:0]  byte_data,
  output logic [1:0]       byte_idx,
  output logic             word_valid,
  output logic [31:0]      word
);

  logic [23:0] r_shift;
  logic [1:0]  r_idx;
  logic        r_word_valid;
  logic [31:0] r_word;

  localparam logic [1:0] c_last_idx = 2'(BYTES_PER_WORD - 1);

  // Shift in bytes MSB first; the fourth byte completes the word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_idx        <= '0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else if (clear) begin
      // The last word stays visible on the write bus; only the partial
      // word and the pulse are discarded.
      r_shift      <= '0;
      r_idx        <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (byte_en) begin
        if (r_idx == c_last_idx) begin
          r_word       <= {r_shift, byte_data};
          r_word_valid <= 1'b1;
          r_idx        <= '0;
        end else begin
          r_shift <= {r_shift[15:0], byte_data};
          r_idx   <= r_idx + 2'd1;
        end
      end
    end
  end

  assign byte_idx   = r_idx;
  assign word_valid = r_word_valid;
  assign word       = r_word;

endmodule : word_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a framed byte stream (count, data, XOR checksum),
//               writes big-endian words to instruction memory and releases
//               the CPU only after a load with a good checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 128,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  input  wire logic        restart_i,
  imem_loader_if.slave     bus,
  output logic             cpu_start_o,
  output logic             err_o,
  output logic [15:0]      words_loaded_o
);

  localparam logic [1:0] c_last_idx = 2'(BYTES_PER_WORD - 1);

  logic [c_state_w-1:0] r_state;
  logic [c_state_w-1:0] w_state_next;
  logic [7:0]           r_count_hi;
  logic [15:0]          r_count;
  logic [7:0]           r_csum;
  logic [15:0]          r_words;
  logic [31:0]          r_wr_addr;
  logic                 r_cpu_start;
  logic                 r_err;

  logic                 w_ready;
  logic                 w_fire;
  logic                 w_restart;
  logic                 w_data_byte;
  logic                 w_word_done;
  logic                 w_last_word;
  logic [15:0]          w_hdr_count;
  logic [1:0]           w_byte_idx;
  logic                 w_word_valid;
  logic [31:0]          w_word;

  assign w_fire      = bus.byte_valid_i && w_ready;
  assign w_restart   = restart_i && ((r_state == S_DONE) || (r_state == S_ERR));
  assign w_data_byte = w_fire && (r_state == S_DATA);
  assign w_word_done = w_data_byte && (w_byte_idx == c_last_idx);
  assign w_last_word = (r_words == (r_count - 16'd1));
  assign w_hdr_count = {r_count_hi, bus.byte_data_i};

  word_assembler u_asm (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .clear      (w_restart),
    .byte_en    (w_data_byte),
    .byte_data  (bus.byte_data_i),
    .byte_idx   (w_byte_idx),
    .word_valid (w_word_valid),
    .word       (w_word)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_HDR0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; all transitions except restart need an accepted byte
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HDR0: if (w_fire) w_state_next = S_HDR1;
      S_HDR1: begin
        if (w_fire) begin
          if (32'(w_hdr_count) > 32'(DEPTH)) begin
            w_state_next = S_ERR;
          end else if (w_hdr_count == 16'd0) begin
            w_state_next = S_CSUM;
          end else begin
            w_state_next = S_DATA;
          end
        end
      end
      S_DATA: if (w_word_done && w_last_word) w_state_next = S_CSUM;
      S_CSUM: begin
        if (w_fire) begin
          w_state_next = (bus.byte_data_i == r_csum) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: if (w_restart) w_state_next = S_HDR0;
      default: w_state_next = S_HDR0;
    endcase
  end

  // Output decode: the loader takes bytes in every framing state
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_HDR0, S_HDR1, S_DATA, S_CSUM: w_ready = 1'b1;
      default:                        w_ready = 1'b0;
    endcase
  end

  // Header, checksum, word counter and write address
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_count_hi <= '0;
      r_count    <= '0;
      r_csum     <= '0;
      r_words    <= '0;
      r_wr_addr  <= BASE_ADDR;
    end else if (w_restart) begin
      r_count_hi <= '0;
      r_count    <= '0;
      r_csum     <= '0;
      r_words    <= '0;
      r_wr_addr  <= BASE_ADDR;
    end else begin
      if (w_fire && (r_state == S_HDR0)) r_count_hi <= bus.byte_data_i;
      if (w_fire && (r_state == S_HDR1)) r_count    <= w_hdr_count;
      if (w_data_byte) r_csum <= r_csum ^ bus.byte_data_i;
      // Address and count update on the same edge that raises the strobe
      if (w_word_done) begin
        r_wr_addr <= BASE_ADDR + {14'd0, r_words, 2'b00};
        r_words   <= r_words + 16'd1;
      end
    end
  end

  // Registered status flags follow the state the FSM is entering
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cpu_start <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cpu_start <= (w_state_next == S_DONE);
      r_err       <= (w_state_next == S_ERR);
    end
  end

  assign bus.byte_ready_o = w_ready;
  assign bus.wr_en_o      = w_word_valid;
  assign bus.wr_data_o    = w_word;
  assign bus.wr_addr_o    = r_wr_addr;
  assign cpu_start_o      = r_cpu_start;
  assign err_o            = r_err;
  assign words_loaded_o   = r_words;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        restart = 1'b0;
  logic        cpu_start;
  logic        err;
  logic [15:0] words_loaded;

  int n_vec = 0;
  int n_err = 0;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(128), .BASE_ADDR(32'd0)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .restart_i      (restart),
    .bus            (bus),
    .cpu_start_o    (cpu_start),
    .err_o          (err),
    .words_loaded_o (words_loaded)
  );

  always #5 clk = ~clk;

  // Write-port monitor, sampled on the falling edge
  int          wr_cnt  = 0;
  int          wide_cnt = 0;
  logic        prev_en = 1'b0;
  logic [31:0] wr_a [64];
  logic [31:0] wr_d [64];

  always @(negedge clk) begin
    if (bus.wr_en_o === 1'b1) begin
      if (wr_cnt < 64) begin
        wr_a[wr_cnt] <= bus.wr_addr_o;
        wr_d[wr_cnt] <= bus.wr_data_o;
      end
      wr_cnt <= wr_cnt + 1;
      if (prev_en) wide_cnt <= wide_cnt + 1;
    end
    prev_en <= (bus.wr_en_o === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    t = 0;
    while (bus.byte_ready_o !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t == 10) chk("ready_timeout", {31'd0, bus.byte_ready_o}, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.byte_valid_i = 1'b0;
    end
  endtask

  logic [7:0] fq [$];

  task automatic send_range(input int lo, input int hi, input int maxgap);
    for (int i = lo; i < hi; i++) begin
      send_byte(fq[i]);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // Two-word frame: data XOR = 20^08^00^05 = 0x2D
  task automatic load_frame_a();
    fq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
  endtask

  int base;

  initial begin
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_ready", {31'd0, bus.byte_ready_o}, 32'd1);
    chk("rst_start", {31'd0, cpu_start}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    chk("rst_wren", {31'd0, bus.wr_en_o}, 32'd0);
    chk("rst_addr", bus.wr_addr_o, 32'd0);
    chk("rst_data", bus.wr_data_o, 32'd0);

    // Two-word load
    load_frame_a();
    base = wr_cnt;
    send_range(0, 10, 0);
    idle(1);
    chk("a_start_pre", {31'd0, cpu_start}, 32'd0);
    send_byte(fq[10]);
    idle(1);
    chk("a_start", {31'd0, cpu_start}, 32'd1);
    chk("a_err", {31'd0, err}, 32'd0);
    chk("a_ready_done", {31'd0, bus.byte_ready_o}, 32'd0);
    chk("a_nwr", 32'(wr_cnt - base), 32'd2);
    chk("a_addr0", wr_a[base], 32'h0000_0000);
    chk("a_data0", wr_d[base], 32'h2008_0005);
    chk("a_addr1", wr_a[base+1], 32'h0000_0004);
    chk("a_data1", wr_d[base+1], 32'h0000_0000);
    chk("a_words", {16'd0, words_loaded}, 32'd2);
    chk("a_hold_addr", bus.wr_addr_o, 32'h0000_0004);
    chk("a_wide", 32'(wide_cnt), 32'd0);

    pulse_restart();
    chk("rs_start", {31'd0, cpu_start}, 32'd0);
    chk("rs_words", {16'd0, words_loaded}, 32'd0);
    chk("rs_addr", bus.wr_addr_o, 32'd0);
    chk("rs_ready", {31'd0, bus.byte_ready_o}, 32'd1);

    // Zero-length frame
    fq = '{8'h00, 8'h00, 8'h00};
    base = wr_cnt;
    send_range(0, 3, 0);
    idle(2);
    chk("z_nwr", 32'(wr_cnt - base), 32'd0);
    chk("z_start", {31'd0, cpu_start}, 32'd1);
    chk("z_err", {31'd0, err}, 32'd0);
    pulse_restart();

    // Oversize count: 0x0081 = 129 > 128
    fq = '{8'h00, 8'h81};
    base = wr_cnt;
    send_range(0, 1, 0);
    idle(1);
    chk("o_err_pre", {31'd0, err}, 32'd0);
    send_byte(fq[1]);
    idle(1);
    chk("o_err", {31'd0, err}, 32'd1);
    chk("o_ready", {31'd0, bus.byte_ready_o}, 32'd0);
    chk("o_start", {31'd0, cpu_start}, 32'd0);
    idle(3);
    chk("o_nwr", 32'(wr_cnt - base), 32'd0);
    pulse_restart();
    chk("o_err_clr", {31'd0, err}, 32'd0);

    // Bubbles with an ignored restart mid-frame
    load_frame_a();
    base = wr_cnt;
    send_range(0, 5, 5);
    pulse_restart();
    send_range(5, 11, 5);
    idle(2);
    chk("b_nwr", 32'(wr_cnt - base), 32'd2);
    chk("b_addr0", wr_a[base], 32'h0000_0000);
    chk("b_data0", wr_d[base], 32'h2008_0005);
    chk("b_addr1", wr_a[base+1], 32'h0000_0004);
    chk("b_data1", wr_d[base+1], 32'h0000_0000);
    chk("b_start", {31'd0, cpu_start}, 32'd1);
    chk("b_words", {16'd0, words_loaded}, 32'd2);
    chk("b_wide", 32'(wide_cnt), 32'd0);
    pulse_restart();

    // Bad checksum: data XOR = 20^08^00^0D = 0x25, 0xFF sent
    fq = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h0D, 8'hFF};
    base = wr_cnt;
    send_range(0, 7, 0);
    idle(2);
    chk("c_nwr", 32'(wr_cnt - base), 32'd1);
    chk("c_data0", wr_d[base], 32'h2008_000D);
    chk("c_err", {31'd0, err}, 32'd1);
    chk("c_start", {31'd0, cpu_start}, 32'd0);
    pulse_restart();
    fq[6] = 8'h25;
    base = wr_cnt;
    send_range(0, 7, 0);
    idle(2);
    chk("c2_start", {31'd0, cpu_start}, 32'd1);
    chk("c2_err", {31'd0, err}, 32'd0);
    chk("c2_addr0", wr_a[base], 32'h0000_0000);
    chk("c2_words", {16'd0, words_loaded}, 32'd1);

    // Reset after two data bytes of word 0
    pulse_restart();
    fq = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    base = wr_cnt;
    send_range(0, 4, 0);
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("r_start", {31'd0, cpu_start}, 32'd0);
    chk("r_err", {31'd0, err}, 32'd0);
    chk("r_words", {16'd0, words_loaded}, 32'd0);
    chk("r_wren", {31'd0, bus.wr_en_o}, 32'd0);
    chk("r_addr", bus.wr_addr_o, 32'd0);
    chk("r_data", bus.wr_data_o, 32'd0);
    idle(4);
    chk("r_nwr", 32'(wr_cnt - base), 32'd0);
    load_frame_a();
    send_range(0, 11, 0);
    idle(2);
    chk("r2_nwr", 32'(wr_cnt - base), 32'd2);
    chk("r2_addr0", wr_a[base], 32'h0000_0000);
    chk("r2_data0", wr_d[base], 32'h2008_0005);
    chk("r2_addr1", wr_a[base+1], 32'h0000_0004);
    chk("r2_start", {31'd0, cpu_start}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_imem_loader
`default_nettype wire
